// File: rtl/key_pkg.sv
// Shared types and helpers for the key debouncer.
//   key_state_t  : debounce FSM state encoding
//   ms_to_cycles : converts a millisecond interval to clock cycles
//   cnt_width    : counter width needed to count to n (at least 1 bit)
package key_pkg;

  localparam int unsigned STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    StInit     = 3'd0,
    StIdle     = 3'd1,
    StPressChk = 3'd2,
    StHeld     = 3'd3,
    StRelChk   = 3'd4
  } key_state_t;

  function automatic int unsigned ms_to_cycles(input int unsigned freq, input int unsigned ms);
    return (freq / 32'd1000) * ms;
  endfunction

  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 32'd1) ? unsigned'($clog2(n)) : 32'd1;
  endfunction

endpackage

// File: rtl/key_debounce_sync2.sv
// Two-flop synchroniser for a single asynchronous level.
//   clk, rst : clock, asynchronous active-high reset
//   i_d      : asynchronous input level
//   o_q      : synchronised level (two cycles of latency)
// RESET_VAL sets the level both flops take during reset.
module sync2 #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_meta <= RESET_VAL;
      r_sync <= RESET_VAL;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/key_debounce.sv
// Push-button debouncer: synchronises a raw key, filters bounce and emits one
// clock-wide pulse per accepted press.
//   clk, rst    : clock, asynchronous active-high reset
//   i_key_raw   : raw asynchronous button level
//   o_key_pulse : one-cycle pulse per accepted press (and per auto-repeat)
//   o_key_level : debounced pressed level, 1 = pressed
//   o_key_long  : high while a long hold is in progress (auto-repeat builds only)
// Optional feature: define KEY_REPEAT_EN to enable hold detection and auto-repeat.
module key_debounce
  import key_pkg::*;
#(
  parameter int unsigned CLK_FREQ    = 12_000_000,
  parameter int unsigned DEBOUNCE_MS = 20,
  parameter int unsigned HOLD_MS     = 1000,
  parameter int unsigned REPEAT_MS   = 200,
  parameter bit          ACTIVE_LOW  = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic i_key_raw,
  output logic o_key_pulse,
  output logic o_key_level,
  output logic o_key_long
);

  localparam int unsigned DB_CYCLES = ms_to_cycles(CLK_FREQ, DEBOUNCE_MS);
  localparam int unsigned DB_W      = cnt_width(DB_CYCLES);

  logic            w_sync;
  logic            w_p;
  logic            r_p_prev;
  key_state_t      r_state, w_state_d;
  logic [DB_W-1:0] r_cnt, w_cnt_d;
  logic            w_db_done;
  logic            w_press_pulse;
  logic            w_rep_pulse;
  logic            r_pulse;
  logic            r_level;

  // Synchroniser idles at the released level so reset never looks like a press.
  sync2 #(
    .RESET_VAL(ACTIVE_LOW)
  ) u_sync (
    .clk (clk),
    .rst (rst),
    .i_d (i_key_raw),
    .o_q (w_sync)
  );

  assign w_p       = w_sync ^ ACTIVE_LOW;
  assign w_db_done = (r_cnt == DB_W'(DB_CYCLES - 1));

  always_comb begin
    w_state_d     = r_state;
    w_cnt_d       = r_cnt;
    w_press_pulse = 1'b0;
    unique case (r_state)
      StInit: begin
        // Settle to whatever level the key has, without ever pulsing.
        if (w_p != r_p_prev) begin
          w_cnt_d = '0;
        end else if (w_db_done) begin
          w_state_d = w_p ? StHeld : StIdle;
        end else begin
          w_cnt_d = r_cnt + 1'b1;
        end
      end
      StIdle: begin
        if (w_p) w_state_d = StPressChk;
      end
      StPressChk: begin
        if (!w_p) begin
          w_state_d = StIdle;
        end else if (w_db_done) begin
          w_state_d     = StHeld;
          w_press_pulse = 1'b1;
        end else begin
          w_cnt_d = r_cnt + 1'b1;
        end
      end
      StHeld: begin
        if (!w_p) w_state_d = StRelChk;
      end
      StRelChk: begin
        if (w_p) begin
          w_state_d = StHeld;
        end else if (w_db_done) begin
          w_state_d = StIdle;
        end else begin
          w_cnt_d = r_cnt + 1'b1;
        end
      end
      default: w_state_d = StInit;
    endcase
    if (w_state_d != r_state) w_cnt_d = '0;
  end

`ifdef KEY_REPEAT_EN
  localparam int unsigned HOLD_CYCLES   = ms_to_cycles(CLK_FREQ, HOLD_MS);
  localparam int unsigned REPEAT_CYCLES = ms_to_cycles(CLK_FREQ, REPEAT_MS);
  localparam int unsigned HOLD_W        = cnt_width(HOLD_CYCLES);
  localparam int unsigned REP_W         = cnt_width(REPEAT_CYCLES);

  logic [HOLD_W-1:0] r_hold_cnt, w_hold_cnt_d;
  logic [REP_W-1:0]  r_rep_cnt, w_rep_cnt_d;
  logic              r_rep_act, w_rep_act_d;
  logic              r_long;

  always_comb begin
    w_hold_cnt_d = '0;
    w_rep_cnt_d  = r_rep_cnt;
    w_rep_act_d  = r_rep_act;
    w_rep_pulse  = 1'b0;
    if (r_state == StHeld && w_state_d == StHeld) begin
      if (!r_rep_act) begin
        if (r_hold_cnt == HOLD_W'(HOLD_CYCLES - 1)) begin
          w_rep_pulse = 1'b1;
          w_rep_act_d = 1'b1;
          w_rep_cnt_d = '0;
        end else begin
          w_hold_cnt_d = r_hold_cnt + 1'b1;
        end
      end else if (r_rep_cnt == REP_W'(REPEAT_CYCLES - 1)) begin
        w_rep_pulse = 1'b1;
        w_rep_cnt_d = '0;
      end else begin
        w_rep_cnt_d = r_rep_cnt + 1'b1;
      end
    end
    // Repeat state survives release bounce; only a real release ends it.
    if (w_state_d == StIdle || w_state_d == StInit) begin
      w_rep_act_d = 1'b0;
      w_rep_cnt_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hold_cnt <= '0;
      r_rep_cnt  <= '0;
      r_rep_act  <= 1'b0;
      r_long     <= 1'b0;
    end else begin
      r_hold_cnt <= w_hold_cnt_d;
      r_rep_cnt  <= w_rep_cnt_d;
      r_rep_act  <= w_rep_act_d;
      r_long     <= (w_state_d == StHeld) && w_rep_act_d;
    end
  end

  assign o_key_long = r_long;
`else
  assign w_rep_pulse = 1'b0;
  assign o_key_long  = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= StInit;
      r_cnt    <= '0;
      r_p_prev <= 1'b0;
      r_pulse  <= 1'b0;
      r_level  <= 1'b0;
    end else begin
      r_state  <= w_state_d;
      r_cnt    <= w_cnt_d;
      r_p_prev <= w_p;
      r_pulse  <= w_press_pulse | w_rep_pulse;
      r_level  <= (w_state_d == StHeld) || (w_state_d == StRelChk);
    end
  end

  assign o_key_pulse = r_pulse;
  assign o_key_level = r_level;

endmodule

// File: tb/tb_key_debounce.sv
// Self-checking bench for key_debounce (DB_CYCLES=4, HOLD_CYCLES=20, REPEAT_CYCLES=5).
module tb_key_debounce;

`ifdef KEY_REPEAT_EN
  localparam bit REP = 1'b1;
`else
  localparam bit REP = 1'b0;
`endif

  logic clk;
  logic rst;
  logic key_raw;
  logic key_pulse;
  logic key_level;
  logic key_long;

  int errors;
  int checks;

  key_debounce #(
    .CLK_FREQ   (1000),
    .DEBOUNCE_MS(4),
    .HOLD_MS    (20),
    .REPEAT_MS  (5),
    .ACTIVE_LOW (1'b1)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .i_key_raw  (key_raw),
    .o_key_pulse(key_pulse),
    .o_key_level(key_level),
    .o_key_long (key_long)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic  raw;
    logic  pulse;
    logic  level;
    string tag;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic raw, input logic pulse, input logic level,
                              input int n, input string tag);
    vec_t v;
    v.raw   = raw;
    v.pulse = pulse;
    v.level = level;
    v.tag   = tag;
    for (int k = 0; k < n; k++) vecs.push_back(v);
  endfunction

  task automatic check(input string name, input logic got, input logic exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, got, exp, $time);
    end
  endtask

  // Apply raw before the next edge, then sample 1 time unit after it.
  task automatic cycle(input logic raw);
    key_raw = raw;
    @(posedge clk);
    #1;
  endtask

  initial begin
    errors  = 0;
    checks  = 0;
    rst     = 1'b1;
    key_raw = 1'b1;

    // Raw = 1 is released (active low). Pulse appears 6 vectors after a press
    // starts; level falls 6 vectors after a release starts.
    add(1'b1, 1'b0, 1'b0, 10, "idle");
    add(1'b0, 1'b0, 1'b0, 6,  "press");
    add(1'b0, 1'b1, 1'b1, 1,  "press");
    add(1'b0, 1'b0, 1'b1, 5,  "press");
    add(1'b1, 1'b0, 1'b1, 6,  "release");
    add(1'b1, 1'b0, 1'b0, 6,  "release");
    add(1'b0, 1'b0, 1'b0, 2,  "bounce");
    add(1'b1, 1'b0, 1'b0, 1,  "bounce");
    add(1'b0, 1'b0, 1'b0, 3,  "bounce");
    add(1'b1, 1'b0, 1'b0, 8,  "bounce");
    add(1'b0, 1'b0, 1'b0, 6,  "press2");
    add(1'b0, 1'b1, 1'b1, 1,  "press2");
    add(1'b0, 1'b0, 1'b1, 5,  "press2");
    add(1'b1, 1'b0, 1'b1, 2,  "relbnc");
    add(1'b0, 1'b0, 1'b1, 1,  "relbnc");
    add(1'b1, 1'b0, 1'b1, 6,  "relbnc");
    add(1'b1, 1'b0, 1'b0, 6,  "relbnc");

    repeat (3) @(posedge clk);
    #1;
    check("reset_pulse", key_pulse, 1'b0);
    check("reset_level", key_level, 1'b0);
    check("reset_long",  key_long,  1'b0);
    rst = 1'b0;

    foreach (vecs[i]) begin
      cycle(vecs[i].raw);
      check({vecs[i].tag, "_pulse"}, key_pulse, vecs[i].pulse);
      check({vecs[i].tag, "_level"}, key_level, vecs[i].level);
      check({vecs[i].tag, "_long"},  key_long,  1'b0);
    end

    // Press into HELD, then assert reset mid-press: outputs clear at once.
    for (int j = 1; j <= 10; j++) begin
      cycle(1'b0);
      check("pre_rst_pulse", key_pulse, (j == 7));
      check("pre_rst_level", key_level, (j >= 7));
    end
    #3 rst = 1'b1;
    #1;
    check("rst_async_pulse", key_pulse, 1'b0);
    check("rst_async_level", key_level, 1'b0);
    check("rst_async_long",  key_long,  1'b0);
    @(posedge clk);
    #1 rst = 1'b0;

    // Key held through reset release: INIT settles to HELD, no pulse.
    for (int j = 1; j <= 12; j++) begin
      cycle(1'b0);
      check("held_rst_pulse", key_pulse, 1'b0);
      check("held_rst_level", key_level, (j >= 7));
    end
    for (int j = 1; j <= 12; j++) begin
      cycle(1'b1);
      check("held_rel_pulse", key_pulse, 1'b0);
      check("held_rel_level", key_level, (j < 7));
    end

    // Long hold: one press pulse at 7, repeats 20/25/30/35/40 later if enabled.
    for (int j = 1; j <= 60; j++) begin
      logic exp_pulse;
      logic exp_long;
      exp_pulse = (j == 7) ||
                  (REP && (j == 27 || j == 32 || j == 37 || j == 42 || j == 47));
      exp_long  = REP && (j >= 27) && (j <= 49);
      cycle((j < 48) ? 1'b0 : 1'b1);
      check("hold_pulse", key_pulse, exp_pulse);
      check("hold_level", key_level, (j >= 7) && (j < 54));
      check("hold_long",  key_long,  exp_long);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
